// File: rtl/gem_resync_pkg.sv
// Shared definitions for the GEM resync controller: FSM state encoding,
// chamber indices and a saturating byte-counter helper.
package gem_resync_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_REQ       = 3'd1,
      ST_WAIT_DONE = 3'd2,
      ST_SETTLE    = 3'd3,
      ST_RETRY     = 3'd4
   } state_e;

   localparam logic CH_A = 1'b0;
   localparam logic CH_B = 1'b1;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/gem_resync_debounce.sv
// Per-chamber loss-of-sync debounce: need asserts once the chamber has been
// out of sync on good links for HOLDOFF_CYC consecutive cycles.
module gem_resync_debounce
#(
   parameter int unsigned HOLDOFF_CYC = 8
) (
   input  logic clock,
   input  logic global_reset_n,
   input  logic synced,
   input  logic link_ok,
   input  logic fail,
   input  logic clr,
   output logic need
);
   import gem_resync_pkg::*;

   localparam int unsigned HW = $clog2(HOLDOFF_CYC + 1);
   localparam logic [HW-1:0] HOLD_V = HW'(HOLDOFF_CYC);

   logic [HW-1:0] cnt_r;
   logic [HW-1:0] cnt_nxt_s;
   logic          need_r;

   // Next holdoff count: clears on any healthy/ineligible cycle, saturates at HOLD_V.
   always_comb begin
      cnt_nxt_s = cnt_r;
      if (clr || synced || !link_ok || fail) begin
         cnt_nxt_s = {HW{1'b0}};
      end else if (cnt_r != HOLD_V) begin
         cnt_nxt_s = cnt_r + {{(HW-1){1'b0}}, 1'b1};
      end else begin
         cnt_nxt_s = cnt_r;
      end
   end

   // Holdoff counter and registered need flag.
   always_ff @(posedge clock or negedge global_reset_n) begin
      if (!global_reset_n) begin
         cnt_r  <= {HW{1'b0}};
         need_r <= 1'b0;
      end else begin
         cnt_r  <= cnt_nxt_s;
         need_r <= (cnt_nxt_s == HOLD_V);
      end
   end

   assign need = need_r;

endmodule

// File: rtl/gem_resync_ctrl.sv
// GEM optical-link resync sequencer: debounces loss of sync per chamber,
// arbitrates one resync resource round-robin, retries and latches failures.
// Optional GEM_RESYNC_CTRL_STATS_EN adds per-chamber WAIT_DONE timeout counters.
module gem_resync_ctrl
   import gem_resync_pkg::*;
#(
   parameter int unsigned HOLDOFF_CYC = 8,
   parameter int unsigned TIMEOUT_CYC = 1024,
   parameter int unsigned SETTLE_CYC  = 64,
   parameter int unsigned MAX_RETRY   = 3,
   parameter int unsigned CNT_W       = 11
) (
   input  logic       clock,
   input  logic       global_reset_n,
   input  logic       enable,
   input  logic [3:0] link_good,
   input  logic       gemA_synced,
   input  logic       gemB_synced,
   input  logic       gemA_sync_done,
   input  logic       gemB_sync_done,
   input  logic       fail_clear,
   output logic       gemA_resync_req,
   output logic       gemB_resync_req,
   output logic       busy,
   output logic       gemA_fail,
   output logic       gemB_fail,
   output logic [7:0] resync_cnt,
`ifdef GEM_RESYNC_CTRL_STATS_EN
   output logic [7:0] gemA_timeout_cnt,
   output logic [7:0] gemB_timeout_cnt,
`endif
   output logic [2:0] fsm_state
);

   localparam int unsigned RW  = $clog2(MAX_RETRY + 1);
   localparam int unsigned RWP = RW + 1;
   localparam logic [RW:0]      RETRY_LIM    = RWP'(MAX_RETRY);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

   state_e           state_r, state_nxt_s;
   logic             sel_r, sel_nxt_s, ptr_r, ptr_nxt_s;
   logic [CNT_W-1:0] cyc_r, cyc_inc_s;
   logic             done_prev_r;
   logic [RW-1:0]    retry_a_r, retry_b_r;
   logic [RW:0]      retry_cur_s, retry_inc_s;
   logic             fail_a_r, fail_b_r;
   logic             need_a_s, need_b_s, elig_a_s, elig_b_s, clr_a_s, clr_b_s;
   logic             link_a_s, link_b_s, synced_sel_s, link_sel_s, done_sel_s, done_rise_s;
   logic             timeout_s, success_s, give_up_s;
   logic             req_a_r, req_b_r, busy_r;
   logic [7:0]       resync_cnt_r;

   assign link_a_s     = &link_good[1:0];
   assign link_b_s     = &link_good[3:2];
   assign elig_a_s     = need_a_s && !fail_a_r;
   assign elig_b_s     = need_b_s && !fail_b_r;
   assign synced_sel_s = (sel_r == CH_B) ? gemB_synced    : gemA_synced;
   assign link_sel_s   = (sel_r == CH_B) ? link_b_s       : link_a_s;
   assign done_sel_s   = (sel_r == CH_B) ? gemB_sync_done : gemA_sync_done;
   assign done_rise_s  = done_sel_s && !done_prev_r;
   assign retry_cur_s  = (sel_r == CH_B) ? {1'b0, retry_b_r} : {1'b0, retry_a_r};
   assign retry_inc_s  = retry_cur_s + {{RW{1'b0}}, 1'b1};
   assign cyc_inc_s    = (cyc_r == CNT_MAX) ? cyc_r : cyc_r + {{(CNT_W-1){1'b0}}, 1'b1};
   assign clr_a_s      = success_s && (sel_r == CH_A);
   assign clr_b_s      = success_s && (sel_r == CH_B);

   gem_resync_debounce #(.HOLDOFF_CYC(HOLDOFF_CYC)) u_deb_a (
      .clock(clock), .global_reset_n(global_reset_n), .synced(gemA_synced),
      .link_ok(link_a_s), .fail(fail_a_r), .clr(clr_a_s), .need(need_a_s)
   );

   gem_resync_debounce #(.HOLDOFF_CYC(HOLDOFF_CYC)) u_deb_b (
      .clock(clock), .global_reset_n(global_reset_n), .synced(gemB_synced),
      .link_ok(link_b_s), .fail(fail_b_r), .clr(clr_b_s), .need(need_b_s)
   );

   // Next-state, arbitration and sequence-event decode.
   always_comb begin
      state_nxt_s = state_r;
      sel_nxt_s   = sel_r;
      ptr_nxt_s   = ptr_r;
      timeout_s   = 1'b0;
      success_s   = 1'b0;
      give_up_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (enable && (elig_a_s || elig_b_s)) begin
               state_nxt_s = ST_REQ;
               if (elig_a_s && elig_b_s) begin
                  sel_nxt_s = ptr_r;
                  ptr_nxt_s = ~ptr_r;
               end else if (elig_a_s) begin
                  sel_nxt_s = CH_A;
               end else begin
                  sel_nxt_s = CH_B;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_REQ: state_nxt_s = ST_WAIT_DONE;
         ST_WAIT_DONE: begin
            if (done_rise_s) begin
               state_nxt_s = ST_SETTLE;
            end else if (cyc_r >= TIMEOUT_LAST) begin
               state_nxt_s = ST_RETRY;
               timeout_s   = 1'b1;
            end else begin
               state_nxt_s = ST_WAIT_DONE;
            end
         end
         ST_SETTLE: begin
            if (!synced_sel_s || !link_sel_s) begin
               state_nxt_s = ST_RETRY;
            end else if (cyc_r >= SETTLE_LAST) begin
               state_nxt_s = ST_IDLE;
               success_s   = 1'b1;
            end else begin
               state_nxt_s = ST_SETTLE;
            end
         end
         ST_RETRY: begin
            if (retry_inc_s >= RETRY_LIM) begin
               state_nxt_s = ST_IDLE;
               give_up_s   = 1'b1;
            end else begin
               state_nxt_s = ST_REQ;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clock or negedge global_reset_n) begin
      if (!global_reset_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Selection, cycle counter, done-edge history and registered outputs.
   always_ff @(posedge clock or negedge global_reset_n) begin
      if (!global_reset_n) begin
         sel_r        <= CH_A;
         ptr_r        <= CH_A;
         busy_r       <= 1'b0;
         req_a_r      <= 1'b0;
         req_b_r      <= 1'b0;
         cyc_r        <= {CNT_W{1'b0}};
         done_prev_r  <= 1'b0;
         resync_cnt_r <= 8'd0;
      end else begin
         sel_r   <= sel_nxt_s;
         ptr_r   <= ptr_nxt_s;
         busy_r  <= (state_nxt_s != ST_IDLE);
         req_a_r <= (state_r == ST_REQ) && (sel_r == CH_A);
         req_b_r <= (state_r == ST_REQ) && (sel_r == CH_B);
         case (state_r)
            ST_REQ:       cyc_r <= {CNT_W{1'b0}};
            ST_WAIT_DONE: cyc_r <= done_rise_s ? {CNT_W{1'b0}} : cyc_inc_s;
            ST_SETTLE:    cyc_r <= cyc_inc_s;
            default:      cyc_r <= cyc_r;
         endcase
         if ((state_r == ST_REQ) || (state_r == ST_WAIT_DONE)) begin
            done_prev_r <= done_sel_s;
         end
         if (state_r == ST_REQ) begin
            resync_cnt_r <= sat_inc8(resync_cnt_r);
         end
      end
   end

   // Retry counts and failure latches; fail_clear never disturbs the FSM.
   always_ff @(posedge clock or negedge global_reset_n) begin
      if (!global_reset_n) begin
         retry_a_r <= {RW{1'b0}};
         retry_b_r <= {RW{1'b0}};
         fail_a_r  <= 1'b0;
         fail_b_r  <= 1'b0;
      end else if (fail_clear) begin
         retry_a_r <= {RW{1'b0}};
         retry_b_r <= {RW{1'b0}};
         fail_a_r  <= 1'b0;
         fail_b_r  <= 1'b0;
      end else if (state_r == ST_RETRY) begin
         if (sel_r == CH_B) begin
            retry_b_r <= retry_inc_s[RW-1:0];
            fail_b_r  <= fail_b_r | give_up_s;
         end else begin
            retry_a_r <= retry_inc_s[RW-1:0];
            fail_a_r  <= fail_a_r | give_up_s;
         end
      end else if (success_s) begin
         if (sel_r == CH_B) begin
            retry_b_r <= {RW{1'b0}};
         end else begin
            retry_a_r <= {RW{1'b0}};
         end
      end
   end

`ifdef GEM_RESYNC_CTRL_STATS_EN
   logic [7:0] tmo_a_r, tmo_b_r;

   // Timeout statistics survive fail_clear; only reset clears them.
   always_ff @(posedge clock or negedge global_reset_n) begin
      if (!global_reset_n) begin
         tmo_a_r <= 8'd0;
         tmo_b_r <= 8'd0;
      end else if (timeout_s) begin
         if (sel_r == CH_B) begin
            tmo_b_r <= sat_inc8(tmo_b_r);
         end else begin
            tmo_a_r <= sat_inc8(tmo_a_r);
         end
      end
   end

   assign gemA_timeout_cnt = tmo_a_r;
   assign gemB_timeout_cnt = tmo_b_r;
`endif

   assign gemA_resync_req = req_a_r;
   assign gemB_resync_req = req_b_r;
   assign busy            = busy_r;
   assign gemA_fail       = fail_a_r;
   assign gemB_fail       = fail_b_r;
   assign resync_cnt      = resync_cnt_r;
   assign fsm_state       = state_r;

endmodule
